// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone adder family: result-queue state, status flags, tag width.
package ks_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ks_q_state_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } ks_flags_t;

  localparam int KS_TAG_W   = 4;
  localparam int KS_FLAGS_W = $bits(ks_flags_t);

endpackage

// File: rtl/ks_result_fifo2.sv
// Two-entry register queue with an occupancy FSM, wrapping 1-bit pointers and a
// registered head so the consumer never sees a combinational path from the producer.
module ks_result_fifo2
  import ks_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [W-1:0] din,
  output ks_q_state_e state,
  output logic [W-1:0] head
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (state != FULL);
  assign do_pop  = pop && (state != EMPTY);

  // head mirrors entry[rd_ptr] whenever the queue is non-empty and keeps the
  // last popped value once it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
      head     <= '0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= din;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        EMPTY: begin
          if (do_push) begin
            state <= ONE;
            head  <= din;
          end
        end
        ONE: begin
          if (do_push && !do_pop) begin
            state <= FULL;
          end else if (do_pop && !do_push) begin
            state <= EMPTY;
          end else if (do_push && do_pop) begin
            head <= din;
          end
        end
        FULL: begin
          if (do_pop) begin
            state <= ONE;
            head  <= entry[~rd_ptr];
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ks_sum_stage.sv
// Sum/flag stage after the Kogge-Stone carry generator: forms sum and status flags
// from carry/propagate and buffers them in a 2-entry queue.
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int N_BIT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_BIT:0]      carry,
  input  logic [N_BIT-1:0]    p,
  input  logic [KS_TAG_W-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_BIT-1:0]    sum,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic                neg,
  output logic [KS_TAG_W-1:0] out_tag
);

  localparam int PAY_W = N_BIT + KS_FLAGS_W + KS_TAG_W;

  logic [N_BIT-1:0] sum_d;
  ks_flags_t        flags_d;
  ks_flags_t        flags_q;
  ks_q_state_e      q_state;
  logic [PAY_W-1:0] head;

  assign sum_d = p ^ carry[N_BIT-1:0];

  always_comb begin
    flags_d      = '0;
    flags_d.cout = carry[N_BIT];
    flags_d.ovf  = carry[N_BIT] ^ carry[N_BIT-1];
    flags_d.zero = (sum_d == '0);
    flags_d.neg  = sum_d[N_BIT-1];
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready and out_valid come from registered occupancy only, so neither side's
  // ready/valid ever depends combinationally on the other side.
  assign in_ready  = (q_state != FULL);
  assign out_valid = (q_state != EMPTY);

  ks_result_fifo2 #(
    .W(PAY_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid && in_ready),
    .pop  (out_valid && out_ready),
    .din  ({sum_d, flags_d, in_tag}),
    .state(q_state),
    .head (head)
  );

  assign {sum, flags_q, out_tag} = head;
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Bench for ks_sum_stage: an 8-bit instance for directed vectors and corner sequences,
// a 32-bit instance fed by a behavioural adder for randomized traffic.
module tb_ks_sum_stage;

  localparam int N_OPS   = 10000;
  localparam int MAX_CYC = 60000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-bit instance
  logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
  logic [8:0] v8_carry;
  logic [7:0] v8_p, v8_sum;
  logic [3:0] v8_tag, v8_out_tag;
  logic       v8_cout, v8_ovf, v8_zero, v8_neg;

  // 32-bit instance
  logic        v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready;
  logic [32:0] v32_carry;
  logic [31:0] v32_p, v32_sum;
  logic [3:0]  v32_tag, v32_out_tag;
  logic        v32_cout, v32_ovf, v32_zero, v32_neg;

  ks_sum_stage #(.N_BIT(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .carry(v8_carry), .p(v8_p), .in_tag(v8_tag),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .sum(v8_sum), .cout(v8_cout), .ovf(v8_ovf), .zero(v8_zero), .neg(v8_neg),
    .out_tag(v8_out_tag)
  );

  ks_sum_stage #(.N_BIT(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .carry(v32_carry), .p(v32_p), .in_tag(v32_tag),
    .out_valid(v32_out_valid), .out_ready(v32_out_ready),
    .sum(v32_sum), .cout(v32_cout), .ovf(v32_ovf), .zero(v32_zero), .neg(v32_neg),
    .out_tag(v32_out_tag)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [39:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] res8();
    return {v8_out_tag, v8_sum, v8_cout, v8_ovf, v8_zero, v8_neg};
  endfunction

  function automatic logic [39:0] res32();
    return {v32_out_tag, v32_sum, v32_cout, v32_ovf, v32_zero, v32_neg};
  endfunction

  // driver tasks
  task automatic drive8(input logic v, input logic [8:0] c, input logic [7:0] pp, input logic [3:0] t);
    v8_in_valid = v;
    v8_carry    = c;
    v8_p        = pp;
    v8_tag      = t;
  endtask

  logic [31:0] a_c, b_c;
  logic        cin_c;
  logic [3:0]  tag_c;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Stands in for the carry generator: carry into bit i is (a+b+cin) ^ a ^ b at bit i.
  task automatic new_op32();
    logic [32:0] full;
    a_c   = pick_operand();
    b_c   = pick_operand();
    cin_c = 1'($urandom_range(0, 1));
    tag_c = 4'($urandom_range(0, 15));
    full  = {1'b0, a_c} + {1'b0, b_c} + {32'd0, cin_c};
    v32_carry = {full[32], full[31:0] ^ a_c ^ b_c};
    v32_p     = a_c ^ b_c;
    v32_tag   = tag_c;
  endtask

  // Reference: plain two's-complement addition.
  function automatic logic [39:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic [3:0] t);
    logic [32:0] full;
    logic [31:0] s;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    s    = full[31:0];
    ov   = (a[31] == b[31]) && (s[31] != a[31]);
    return {t, s, full[32], ov, (s == 32'd0), s[31]};
  endfunction

  typedef struct {
    logic [8:0] carry;
    logic [7:0] p;
    logic [3:0] tag;
    logic [7:0] sum;
    logic [3:0] flags;  // {cout, ovf, zero, neg}
  } vec_t;

  vec_t tv [8];

  int          sent, recv, cyc;
  bit          accepted, prev_stall;
  logic [39:0] prev_head;

  initial begin
    tv[0] = '{9'h0FE, 8'h7E, 4'd3,  8'h80, 4'b0101};
    tv[1] = '{9'h1FE, 8'hFE, 4'd4,  8'h00, 4'b1010};
    tv[2] = '{9'h000, 8'h55, 4'd1,  8'h55, 4'b0000};
    tv[3] = '{9'h100, 8'h00, 4'd2,  8'h00, 4'b1110};
    tv[4] = '{9'h180, 8'h00, 4'd6,  8'h80, 4'b1001};
    tv[5] = '{9'h0FF, 8'hFF, 4'd9,  8'h00, 4'b0110};
    tv[6] = '{9'h001, 8'h80, 4'd15, 8'h81, 4'b0001};
    tv[7] = '{9'h07F, 8'h7F, 4'd10, 8'h00, 4'b0010};

    drive8(1'b0, '0, '0, '0);
    v8_out_ready  = 1'b1;
    v32_in_valid  = 1'b0;
    v32_carry     = '0;
    v32_p         = '0;
    v32_tag       = '0;
    v32_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst8_out_valid", v8_out_valid, 1'b0);
    check("rst8_in_ready", v8_in_ready, 1'b1);
    check("rst8_payload", res8(), 16'h0);
    check("rst32_out_valid", v32_out_valid, 1'b0);
    check("rst32_payload", res32(), 40'h0);

    // table-driven single transactions, one-cycle latency from EMPTY
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive8(1'b1, tv[i].carry, tv[i].p, tv[i].tag);
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), v8_out_valid, 1'b1);
      check($sformatf("vec%0d_res", i), res8(), {tv[i].tag, tv[i].sum, tv[i].flags});
    end
    @(posedge clk); #1;

    // backpressure: fill to FULL, hold third, then drain in order
    v8_out_ready = 1'b0;
    drive8(1'b1, 9'h000, 8'h01, 4'd1);
    @(posedge clk); #1;
    drive8(1'b1, 9'h000, 8'h02, 4'd2);
    @(posedge clk); #1;
    drive8(1'b1, 9'h000, 8'h03, 4'd3);
    @(negedge clk);
    check("bp_in_ready_full", v8_in_ready, 1'b0);
    check("bp_head1", {v8_out_valid, v8_out_tag, v8_sum}, {1'b1, 4'd1, 8'h01});
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold_ready", v8_in_ready, 1'b0);
    check("bp_hold_head1", {v8_out_tag, v8_sum}, {4'd1, 8'h01});
    @(posedge clk); #1;
    v8_out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", v8_out_tag, 4'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_out2", {v8_out_valid, v8_out_tag, v8_sum}, {1'b1, 4'd2, 8'h02});
    check("bp_ready_after_pop", v8_in_ready, 1'b1);
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    @(negedge clk);
    check("bp_out3", {v8_out_valid, v8_out_tag, v8_sum}, {1'b1, 4'd3, 8'h03});
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_empty", v8_out_valid, 1'b0);
    check("bp_hold_last", {v8_out_tag, v8_sum}, {4'd3, 8'h03});

    // push and pop together while ONE: head replaced, occupancy stays ONE
    @(posedge clk); #1;
    v8_out_ready = 1'b0;
    drive8(1'b1, 9'h000, 8'h44, 4'd4);
    @(posedge clk); #1;
    drive8(1'b1, 9'h000, 8'h55, 4'd5);
    v8_out_ready = 1'b1;
    @(negedge clk);
    check("pp_head4", v8_out_tag, 4'd4);
    @(posedge clk); #1;
    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b0;
    @(negedge clk);
    check("pp_head5", {v8_out_valid, v8_out_tag, v8_sum}, {1'b1, 4'd5, 8'h55});
    check("pp_still_one", v8_in_ready, 1'b1);
    @(posedge clk); #1;
    drive8(1'b1, 9'h000, 8'h66, 4'd6);
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    @(negedge clk);
    check("pp_now_full", v8_in_ready, 1'b0);
    check("pp_head5_kept", v8_out_tag, 4'd5);
    @(posedge clk); #1;
    v8_out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pp_out6", v8_out_tag, 4'd6);
    @(posedge clk); #1;

    // asynchronous reset with two entries buffered
    v8_out_ready = 1'b0;
    drive8(1'b1, 9'h000, 8'h77, 4'd7);
    @(posedge clk); #1;
    drive8(1'b1, 9'h000, 8'h88, 4'd8);
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    @(negedge clk);
    check("ar_full", {v8_in_ready, v8_out_tag}, {1'b0, 4'd7});
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("ar_out_valid_now", v8_out_valid, 1'b0);
    check("ar_in_ready_now", v8_in_ready, 1'b1);
    check("ar_payload_now", res8(), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    v8_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ar_no_stale", {v8_out_valid, res8()}, 17'h0);
    end

    // randomized traffic on the 32-bit instance
    @(posedge clk); #1;
    new_op32();
    v32_in_valid = 1'b1;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_head  = '0;
    while (recv < N_OPS && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (prev_stall)
        check("rnd_stable", res32(), prev_head);
      if (v32_out_valid && v32_out_ready) begin
        if (exp_q.size() == 0)
          check("rnd_unexpected", v32_out_valid, 1'b0);
        else
          check("rnd_res", res32(), exp_q.pop_front());
        recv++;
      end
      prev_stall = v32_out_valid && !v32_out_ready;
      prev_head  = res32();
      accepted = v32_in_valid && v32_in_ready;
      if (accepted) begin
        exp_q.push_back(model32(a_c, b_c, cin_c, tag_c));
        sent++;
      end
      @(posedge clk); #1;
      if (accepted || !v32_in_valid) begin
        if (sent < N_OPS && $urandom_range(0, 7) != 0) begin
          new_op32();
          v32_in_valid = 1'b1;
        end else begin
          v32_in_valid = 1'b0;
        end
      end
      v32_out_ready = ($urandom_range(0, 3) != 0);
    end
    v32_in_valid = 1'b0;
    check("rnd_count", recv, N_OPS);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
